gate_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for the Ch1 gate bank (Not, Nand, And, Or, Xor).
//  - Drives all 2-bit {b,a} input combinations for LOOPS sweeps.
//  - Waits SETTLE cycles per vector, then compares observed outputs against an internal golden model.
//  - Reports pass/fail, a failure count and the first failing vector and mask.
//  - Sits between the test top level and the combinational gate bank.

---
 rtl/gate_bist_ctrl.sv | 112 +++++++++++
 tb/tb_gate_bist_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST sequencer for the Ch1 gate bank (not, nand, and, or, xor)
// Ports: clock, reset (sync, active-high); start requests a run from IDLE;
//   vec_a/vec_b drive the gate bank and obs returns {xor,or,and,nand,not(a)};
//   busy is high in SETTLE/CHECK, done pulses once per run; pass, fail_cnt,
//   first_vec and first_mask report the last run and hold until the next start.
// Option: define GATE_BIST_STOP_ON_FAIL_EN to end a run at its first failing CHECK.
module gate_bist_ctrl #(
  parameter int SETTLE = 1,
  parameter int LOOPS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       vec_a,
  output logic       vec_b,
  input  logic [4:0] obs,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_cnt,
  output logic [1:0] first_vec,
  output logic [4:0] first_mask
);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;
  state_t state, state_n;
  logic [1:0] vec, vec_n, first_vec_n;
  logic [3:0] settle_cnt, settle_n;
  logic [7:0] loop_cnt, loop_n, fail_n;
  logic [4:0] golden, mism, first_mask_n;
  logic pass_n, last;
  assign golden = {vec[0] ^ vec[1], vec[0] | vec[1], vec[0] & vec[1], ~(vec[0] & vec[1]), ~vec[0]};
  assign mism = obs ^ golden;
  // a failing CHECK ends the run early only in stop-on-fail builds
  assign last = (vec == 2'b11 && loop_cnt == LOOP_LAST) || (STOP && mism != 5'd0);
  assign {vec_b, vec_a} = vec;
  assign busy = state == S_SETTLE || state == S_CHECK;
  assign done = state == S_DONE;
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_IDLE;
      vec <= 2'b00;
      settle_cnt <= 4'd0;
      loop_cnt <= 8'd0;
      fail_cnt <= 8'd0;
      first_vec <= 2'b00;
      first_mask <= 5'd0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      vec <= vec_n;
      settle_cnt <= settle_n;
      loop_cnt <= loop_n;
      fail_cnt <= fail_n;
      first_vec <= first_vec_n;
      first_mask <= first_mask_n;
      pass <= pass_n;
    end
  always_comb begin
    state_n = state;
    vec_n = vec;
    settle_n = settle_cnt;
    loop_n = loop_cnt;
    fail_n = fail_cnt;
    first_vec_n = first_vec;
    first_mask_n = first_mask;
    pass_n = pass;
    case (state)
      S_IDLE:
        if (start) begin
          state_n = S_SETTLE;
          vec_n = 2'b00;
          settle_n = 4'd0;
          loop_n = 8'd0;
          fail_n = 8'd0;
          first_vec_n = 2'b00;
          first_mask_n = 5'd0;
          pass_n = 1'b0;
        end
      S_SETTLE: begin
        settle_n = settle_cnt + 4'd1;
        state_n = settle_cnt == SETTLE_LAST ? S_CHECK : S_SETTLE;
      end
      S_CHECK: begin
        if (mism != 5'd0) begin
          fail_n = fail_cnt == 8'hff ? fail_cnt : fail_cnt + 8'd1;
          // fail_cnt never returns to zero once counting, so zero means first failure
          if (fail_cnt == 8'd0) begin
            first_vec_n = vec;
            first_mask_n = mism;
          end
        end
        if (last) begin
          state_n = S_DONE;
          pass_n = fail_n == 8'd0;
        end else begin
          state_n = S_SETTLE;
          vec_n = vec + 2'd1;
          loop_n = vec == 2'b11 ? loop_cnt + 8'd1 : loop_cnt;
          settle_n = 4'd0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: self-checking bench for gate_bist_ctrl (two configurations)
module tb_gate_bist_ctrl;
  localparam int SP [2] = '{1, 3};
  localparam int LP [2] = '{1, 2};
  // truth table of a good gate bank, indexed by {b,a}: {xor,or,and,nand,not(a)}
  localparam logic [4:0] GOLD [4] = '{5'b00011, 5'b11010, 5'b11011, 5'b01100};
  logic clock;
  logic rst [2];
  logic start [2];
  logic va [2], vb [2], busy_o [2], done_o [2], pass_o [2];
  logic [7:0] fc [2];
  logic [1:0] fv [2];
  logic [4:0] fm [2], obs [2], noise [2];
  logic [4:0] fault [2][4];
  logic [4:0] ff [2][4];
  bit run [2];
  int kk [2], rn [2], cn [2];
  int n_chk, n_fail;
  int k, e_nf, lat, cnt;
  logic [1:0] e_fv, e_v, v;
  logic [4:0] e_fm;
  logic e_b, e_d, e_p;

  gate_bist_ctrl #(.SETTLE(1), .LOOPS(1)) u0 (
    .clock(clock), .reset(rst[0]), .start(start[0]), .vec_a(va[0]), .vec_b(vb[0]),
    .obs(obs[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .fail_cnt(fc[0]), .first_vec(fv[0]), .first_mask(fm[0]));
  gate_bist_ctrl #(.SETTLE(3), .LOOPS(2)) u1 (
    .clock(clock), .reset(rst[1]), .start(start[1]), .vec_a(va[1]), .vec_b(vb[1]),
    .obs(obs[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .fail_cnt(fc[1]), .first_vec(fv[1]), .first_mask(fm[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // number of CHECKs the run will perform, decided by the fault pattern at start
  function automatic int checks(input int i);
    int c = 4 * LP[i];
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    for (int j = 3; j >= 0; j--) if (fault[i][j] != 5'd0) c = j + 1;
`endif
    return c;
  endfunction

  // result after nchk completed CHECKs of the current run
  function automatic void tally(input int i, input int nchk, output int nf,
                                output logic [1:0] f_v, output logic [4:0] f_m);
    nf = 0; f_v = 2'd0; f_m = 5'd0;
    for (int j = 0; j < nchk && j < cn[i]; j++)
      if (ff[i][j % 4] != 5'd0) begin
        if (nf == 0) begin f_v = 2'(j % 4); f_m = ff[i][j % 4]; end
        nf = nf < 255 ? nf + 1 : 255;
      end
  endfunction

  // gate bank: correct outputs xor injected faults; noise during settle phases
  always_comb
    for (int i = 0; i < 2; i++) begin
      v = {vb[i], va[i]};
      obs[i] = (run[i] && kk[i] < rn[i] && (kk[i] % (SP[i] + 1)) != SP[i]) ? noise[i] : GOLD[v] ^ fault[i][v];
    end

  // model: kk counts edges since the accepting edge of the current run
  always @(posedge clock)
    for (int i = 0; i < 2; i++) begin
      noise[i] <= 5'($urandom);
      if (rst[i]) run[i] <= 1'b0;
      else if ((!run[i] || kk[i] > rn[i]) && start[i]) begin
        run[i] <= 1'b1;
        kk[i] <= 0;
        cn[i] <= checks(i);
        rn[i] <= checks(i) * (SP[i] + 1);
        for (int j = 0; j < 4; j++) ff[i][j] <= fault[i][j];
      end else if (run[i] && kk[i] <= rn[i]) kk[i] <= kk[i] + 1;
    end

  always @(negedge clock)
    for (int i = 0; i < 2; i++) begin
      if (!run[i]) begin
        e_b = 0; e_d = 0; e_p = 0; e_v = 0; e_nf = 0; e_fv = 0; e_fm = 0;
      end else begin
        k = kk[i] > rn[i] ? rn[i] : kk[i];
        e_b = k < rn[i];
        e_d = kk[i] == rn[i];
        e_v = e_b ? 2'((k / (SP[i] + 1)) % 4) : 2'((cn[i] - 1) % 4);
        tally(i, k / (SP[i] + 1), e_nf, e_fv, e_fm);
        e_p = !e_b && e_nf == 0;
      end
      chk("busy", i, busy_o[i], e_b);
      chk("done", i, done_o[i], e_d);
      chk("vec", i, {vb[i], va[i]}, e_v);
      chk("pass", i, pass_o[i], e_p);
      chk("fail_cnt", i, fc[i], e_nf);
      chk("first_vec", i, fv[i], e_fv);
      chk("first_mask", i, fm[i], e_fm);
    end

  // pulse start; lat = edges from the accepting edge to the edge sampling done high
  task automatic launch(input int i, output int l);
    @(negedge clock); start[i] = 1'b1;
    @(negedge clock); start[i] = 1'b0;
    l = 1;
    while (!done_o[i] && l < 300) begin @(negedge clock); l++; end
  endtask

  initial begin
    rst = '{1'b1, 1'b1};
    start = '{1'b0, 1'b0};
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) fault[i][j] = 5'd0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 0, busy_o[0], 0);
    chk("rst_fail_cnt", 0, fc[0], 0);
    chk("rst_vec", 0, {vb[0], va[0]}, 0);
    rst = '{1'b0, 1'b0};
    // good bank, SETTLE=1 LOOPS=1
    launch(0, lat);
    chk("t1_latency", 0, lat, 9);
    chk("t1_pass", 0, pass_o[0], 1);
    chk("t1_fail_cnt", 0, fc[0], 0);
    // xor stuck-at-0
    fault[0] = '{5'h00, 5'h10, 5'h10, 5'h00};
    launch(0, lat);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    chk("t3_latency", 0, lat, 5);
    chk("t3_fail_cnt", 0, fc[0], 1);
    chk("t3_vec", 0, {vb[0], va[0]}, 1);
`else
    chk("t2_latency", 0, lat, 9);
    chk("t2_fail_cnt", 0, fc[0], 2);
`endif
    chk("t2_first_vec", 0, fv[0], 1);
    chk("t2_first_mask", 0, fm[0], 5'b10000);
    chk("t2_pass", 0, pass_o[0], 0);
    repeat (4) @(negedge clock);
    chk("t2_hold_first_mask", 0, fm[0], 5'b10000);
    // not(a) stuck-at-1
    fault[0] = '{5'h00, 5'h01, 5'h00, 5'h01};
    launch(0, lat);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    chk("not_latency", 0, lat, 5);
`else
    chk("not_fail_cnt", 0, fc[0], 2);
`endif
    chk("not_first_mask", 0, fm[0], 5'b00001);
    // SETTLE=3 LOOPS=2, good bank then every vector failing the and gate
    launch(1, lat);
    chk("t4_latency", 1, lat, 33);
    chk("t4_pass", 1, pass_o[1], 1);
    fault[1] = '{5'h04, 5'h04, 5'h04, 5'h04};
    launch(1, lat);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    chk("all_latency", 1, lat, 5);
    chk("all_fail_cnt", 1, fc[1], 1);
`else
    chk("all_latency", 1, lat, 33);
    chk("all_fail_cnt", 1, fc[1], 8);
`endif
    chk("all_first_vec", 1, fv[1], 0);
    // reset sampled at edge t+4 of a failing run
    fault[0] = '{5'h01, 5'h00, 5'h00, 5'h00};
    @(negedge clock); start[0] = 1'b1;
    @(negedge clock); start[0] = 1'b0;
    repeat (3) @(negedge clock);
    rst[0] = 1'b1;
    @(negedge clock);
    chk("t5_busy", 0, busy_o[0], 0);
    chk("t5_vec", 0, {vb[0], va[0]}, 0);
    chk("t5_fail_cnt", 0, fc[0], 0);
    rst[0] = 1'b0;
    cnt = 0;
    repeat (12) begin @(negedge clock); cnt += int'(done_o[0]); end
    chk("t5_no_done", 0, cnt, 0);
    fault[0] = '{5'h00, 5'h00, 5'h00, 5'h00};
    launch(0, lat);
    chk("t5_relaunch_latency", 0, lat, 9);
    chk("t5_relaunch_pass", 0, pass_o[0], 1);
    // start pulses while busy are ignored
    @(negedge clock); start[0] = 1'b1;
    @(negedge clock); start[0] = 1'b0;
    lat = 1;
    while (!done_o[0] && lat < 300) begin
      @(negedge clock);
      lat++;
      start[0] = lat == 3 || lat == 6;
    end
    start[0] = 1'b0;
    chk("t6_pulse_latency", 0, lat, 9);
    // start held high re-arms right after DONE
    @(negedge clock); start[0] = 1'b1;
    cnt = 0;
    while (!done_o[0] && cnt < 300) begin @(negedge clock); cnt++; end
    cnt = 0;
    @(negedge clock);
    while (!done_o[0] && cnt < 300) begin @(negedge clock); cnt++; end
    start[0] = 1'b0;
    chk("t6_rearm_gap", 0, cnt + 1, 10);
    repeat (15) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
